// File: rtl/sata_cmd_arb_if.sv
// Bundle of per-channel command/response handshakes and the transport
// layer host port shared by all channels. The arbiter sits on the slave
// modport; host engines and the transport model sit on the master side.
interface sata_cmd_arb_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // channel command side
    logic [NUM_CH-1:0]        ch_wr_valid;
    logic [NUM_CH*ADDR_W-1:0] ch_wr_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wr_data;
    logic [NUM_CH-1:0]        ch_wr_last;
    logic [NUM_CH-1:0]        ch_wr_ready;
    // channel response side
    logic [NUM_CH-1:0]        rsp_valid;
    logic [NUM_CH-1:0]        rsp_ready;
    logic [DATA_W-1:0]        rsp_status;
    logic [1:0]               rsp_code;
    // transport host port
    logic                     host_write_en;
    logic                     host_read_en;
    logic [ADDR_W-1:0]        host_addr_reg;
    logic [DATA_W-1:0]        host_data_in;
    logic [DATA_W-1:0]        host_data_out;
    logic                     write_hold_u;
    logic                     cmd_done;
    logic                     ipf;
    logic                     r_err;
    logic                     illegal_state;
    logic                     linkup;

    modport slave (
        input  ch_wr_valid, ch_wr_addr, ch_wr_data, ch_wr_last, rsp_ready,
        input  host_data_out, write_hold_u, cmd_done, ipf, r_err,
        input  illegal_state, linkup,
        output ch_wr_ready, rsp_valid, rsp_status, rsp_code,
        output host_write_en, host_read_en, host_addr_reg, host_data_in
    );

    modport master (
        output ch_wr_valid, ch_wr_addr, ch_wr_data, ch_wr_last, rsp_ready,
        output host_data_out, write_hold_u, cmd_done, ipf, r_err,
        output illegal_state, linkup,
        input  ch_wr_ready, rsp_valid, rsp_status, rsp_code,
        input  host_write_en, host_read_en, host_addr_reg, host_data_in
    );
endinterface

// File: rtl/sata_cmd_arb.sv
// Round-robin N-channel command arbiter in front of one SATA transport
// host port. Serialises one channel's shadow-register writes, waits for
// completion/error/timeout, reads the status register back and returns a
// per-channel response. Link loss aborts the command with code 3.
module sata_cmd_arb #(
    parameter int                NUM_CH         = 4,
    parameter int                ADDR_W         = 5,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] STATUS_ADDR    = 5'h07,
    parameter logic [31:0]       TIMEOUT_CYCLES = 32'd1000000
) (
    input logic           clk,
    input logic           reset,
    sata_cmd_arb_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [1:0] CODE_OK   = 2'd0;
    localparam logic [1:0] CODE_DEV  = 2'd1;
    localparam logic [1:0] CODE_TMO  = 2'd2;
    localparam logic [1:0] CODE_LINK = 2'd3;

    // last timer value of the completion window; 32-bit unsigned so the
    // full 2^32-1 range is representable and the timer never wraps
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_READ_STAT, S_CAPTURE, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [31:0]         timer_q, timer_d;
    logic                host_write_en_q, host_write_en_d;
    logic                host_read_en_q, host_read_en_d;
    logic [ADDR_W-1:0]   host_addr_q, host_addr_d;
    logic [DATA_W-1:0]   host_data_q, host_data_d;
    logic [DATA_W-1:0]   rsp_status_q, rsp_status_d;
    logic [1:0]          rsp_code_q, rsp_code_d;
    logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
    logic [NUM_CH-1:0]   ch_wr_ready_s;
    logic                rr_hit_s;
    logic [CH_W-1:0]     rr_sel_s;
    logic [CH_W:0]       rr_sum_s;
    logic                link_lost_s;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign link_lost_s = ~bus.linkup &&
                         (state_q inside {S_ISSUE, S_WAIT_DONE, S_READ_STAT, S_CAPTURE});

    // Round-robin search: first valid channel at or above ptr, wrapping.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_sel_s = '0;
        rr_sum_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rr_sum_s = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (rr_sum_s >= (CH_W+1)'(NUM_CH)) begin
                rr_sum_s = rr_sum_s - (CH_W+1)'(NUM_CH);
            end else begin
                rr_sum_s = rr_sum_s;
            end
            if (!rr_hit_s && bus.ch_wr_valid[rr_sum_s[CH_W-1:0]]) begin
                rr_hit_s = 1'b1;
                rr_sel_s = rr_sum_s[CH_W-1:0];
            end else begin
                rr_hit_s = rr_hit_s;
                rr_sel_s = rr_sel_s;
            end
        end
    end

    // Next-state and output decode for the command sequencer.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant_d         = grant_q;
        timer_d         = timer_q;
        host_write_en_d = 1'b0;
        host_read_en_d  = 1'b0;
        host_addr_d     = host_addr_q;
        host_data_d     = host_data_q;
        rsp_status_d    = rsp_status_q;
        rsp_code_d      = rsp_code_q;
        rsp_valid_d     = '0;
        ch_wr_ready_s   = '0;
        if (link_lost_s) begin
            // abort: remaining writes stay unaccepted, report link loss
            state_d      = S_RESP;
            rsp_code_d   = CODE_LINK;
            rsp_status_d = '0;
            rsp_valid_d  = ch_onehot(grant_q);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.linkup && rr_hit_s) begin
                        grant_d = rr_sel_s;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // hold gates ready combinationally so a held cycle never
                    // accepts a write the transport cannot take
                    ch_wr_ready_s[grant_q] = ~bus.write_hold_u;
                    if (!bus.write_hold_u && bus.ch_wr_valid[grant_q]) begin
                        host_write_en_d = 1'b1;
                        host_addr_d     = bus.ch_wr_addr[int'(grant_q)*ADDR_W +: ADDR_W];
                        host_data_d     = bus.ch_wr_data[int'(grant_q)*DATA_W +: DATA_W];
                        if (bus.ch_wr_last[grant_q]) begin
                            state_d = S_WAIT_DONE;
                            timer_d = 32'd0;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_WAIT_DONE: begin
                    // errors win over a simultaneous completion
                    if (bus.r_err || bus.illegal_state) begin
                        state_d        = S_READ_STAT;
                        rsp_code_d     = CODE_DEV;
                        host_read_en_d = 1'b1;
                        host_addr_d    = STATUS_ADDR;
                    end else if (bus.cmd_done || bus.ipf) begin
                        state_d        = S_READ_STAT;
                        rsp_code_d     = CODE_OK;
                        host_read_en_d = 1'b1;
                        host_addr_d    = STATUS_ADDR;
                    end else if (timer_q == TMO_LAST) begin
                        state_d        = S_READ_STAT;
                        rsp_code_d     = CODE_TMO;
                        host_read_en_d = 1'b1;
                        host_addr_d    = STATUS_ADDR;
                    end else if (timer_q != 32'hFFFF_FFFF) begin
                        timer_d = timer_q + 32'd1;
                    end else begin
                        timer_d = timer_q;
                    end
                end
                S_READ_STAT: begin
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_status_d = bus.host_data_out;
                    rsp_valid_d  = ch_onehot(grant_q);
                    state_d      = S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        state_d = S_IDLE;
                        if (grant_q == CH_W'(NUM_CH-1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = grant_q + CH_W'(1);
                        end
                    end else begin
                        rsp_valid_d = ch_onehot(grant_q);
                        state_d     = S_RESP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            grant_q         <= '0;
            timer_q         <= 32'd0;
            host_write_en_q <= 1'b0;
            host_read_en_q  <= 1'b0;
            host_addr_q     <= '0;
            host_data_q     <= '0;
            rsp_status_q    <= '0;
            rsp_code_q      <= 2'd0;
            rsp_valid_q     <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            grant_q         <= grant_d;
            timer_q         <= timer_d;
            host_write_en_q <= host_write_en_d;
            host_read_en_q  <= host_read_en_d;
            host_addr_q     <= host_addr_d;
            host_data_q     <= host_data_d;
            rsp_status_q    <= rsp_status_d;
            rsp_code_q      <= rsp_code_d;
            rsp_valid_q     <= rsp_valid_d;
        end
    end

    assign bus.ch_wr_ready   = ch_wr_ready_s;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.rsp_code      = rsp_code_q;
    assign bus.host_write_en = host_write_en_q;
    assign bus.host_read_en  = host_read_en_q;
    assign bus.host_addr_reg = host_addr_q;
    assign bus.host_data_in  = host_data_q;
endmodule

// File: tb/tb_sata_cmd_arb.sv
// Directed bench for sata_cmd_arb: single command, round-robin, write
// hold, timeout, error codes, link loss and reset while responding.
module tb_sata_cmd_arb;
    localparam int NCH = 4;
    localparam int AW  = 5;
    localparam int DW  = 32;

    logic clk;
    logic reset;

    sata_cmd_arb_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sata_cmd_arb #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
        .STATUS_ADDR(5'h07), .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp;
    int n_err;
    int cyc;
    int multi_rdy;
    int last_hs_cyc;
    int rsp_seen_cyc;
    logic [NCH-1:0] hs_s;
    logic [37:0]    ch_q [NCH][$];
    logic [36:0]    wr_log [$];
    int             wr_cyc [$];
    logic [4:0]     rd_addr [$];
    int             rd_cyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // compare, count, report
    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // present the head of each channel queue on the bus
    task automatic drive_ch();
        logic [NCH-1:0]    v;
        logic [NCH-1:0]    l;
        logic [NCH*AW-1:0] a;
        logic [NCH*DW-1:0] d;
        logic [37:0]       e;
        v = '0; l = '0; a = '0; d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_q[c].size() > 0) begin
                e = ch_q[c][0];
                v[c] = 1'b1;
                l[c] = e[37];
                a[c*AW +: AW] = e[36:32];
                d[c*DW +: DW] = e[31:0];
            end
        end
        bus.ch_wr_valid = v;
        bus.ch_wr_last  = l;
        bus.ch_wr_addr  = a;
        bus.ch_wr_data  = d;
    endtask

    task automatic push_wr(input int ch, input logic last, input logic [4:0] addr, input logic [31:0] data);
        ch_q[ch].push_back({last, addr, data});
        drive_ch();
    endtask

    // one clock: observe outputs, cross the edge, retire handshakes
    task automatic tick();
        #1;
        hs_s = bus.ch_wr_valid & bus.ch_wr_ready;
        if ($countones(bus.ch_wr_ready) > 1) multi_rdy++;
        if (bus.host_write_en) begin
            wr_log.push_back({bus.host_addr_reg, bus.host_data_in});
            wr_cyc.push_back(cyc);
        end
        if (bus.host_read_en) begin
            rd_addr.push_back(bus.host_addr_reg);
            rd_cyc.push_back(cyc);
        end
        if (hs_s != '0) last_hs_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (hs_s[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
        end
        drive_ch();
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) ch_q[c].delete();
        drive_ch();
        bus.cmd_done = 1'b0; bus.ipf = 1'b0; bus.r_err = 1'b0;
        bus.illegal_state = 1'b0; bus.write_hold_u = 1'b0; bus.rsp_ready = '0;
        tick(); tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_hs(input int ch);
        int n;
        n = 0;
        tick();
        while (hs_s[ch] == 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk_eq("hs_seen", 64'(hs_s[ch]), 64'd1);
    endtask

    task automatic wait_rsp(input int ch, input logic [1:0] code, input logic [31:0] st, input int hold);
        int n;
        logic [NCH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        rsp_seen_cyc = cyc;
        chk_eq("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
        chk_eq("rsp_code", 64'(bus.rsp_code), 64'(code));
        chk_eq("rsp_status", 64'(bus.rsp_status), 64'(st));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk_eq("rsp_hold_valid", 64'(bus.rsp_valid), 64'(oh));
            chk_eq("rsp_hold_status", 64'(bus.rsp_status), 64'(st));
        end
        bus.rsp_ready = oh;
        tick();
        bus.rsp_ready = '0;
        chk_eq("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hs;
        int done_c;
        int hold_c;
        int nh;
        int drop_c;
        int n;
        n_cmp = 0; n_err = 0; cyc = 0; multi_rdy = 0; last_hs_cyc = 0; rsp_seen_cyc = 0;
        hs_s = '0;
        reset = 1'b1;
        bus.linkup = 1'b1;
        bus.host_data_out = 32'd0;
        reset_dut();

        // reset state
        chk_eq("rst_ready", 64'(bus.ch_wr_ready), 64'd0);
        chk_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk_eq("rst_wr_en", 64'(bus.host_write_en), 64'd0);
        chk_eq("rst_rd_en", 64'(bus.host_read_en), 64'd0);
        chk_eq("rst_addr", 64'(bus.host_addr_reg), 64'd0);
        chk_eq("rst_data", 64'(bus.host_data_in), 64'd0);
        chk_eq("rst_status", 64'(bus.rsp_status), 64'd0);
        chk_eq("rst_code", 64'(bus.rsp_code), 64'd0);

        // single channel: three writes, completion, status read
        bus.host_data_out = 32'h0000_0050;
        done_c = cyc;
        push_wr(0, 1'b0, 5'd2, 32'h0000_1111);
        push_wr(0, 1'b0, 5'd4, 32'h0000_2222);
        push_wr(0, 1'b1, 5'd7, 32'h0000_3333);
        wait_hs(0);
        first_hs = last_hs_cyc;
        chk_eq("grant_latency", 64'(first_hs - done_c), 64'd1);
        repeat (11) tick();
        bus.cmd_done = 1'b1;
        done_c = cyc;
        tick();
        bus.cmd_done = 1'b0;
        wait_rsp(0, 2'd0, 32'h0000_0050, 3);
        chk_eq("t1_nwr", 64'(wr_log.size()), 64'd3);
        chk_eq("t1_wr0", 64'(wr_log[0]), 64'({5'd2, 32'h0000_1111}));
        chk_eq("t1_wr1", 64'(wr_log[1]), 64'({5'd4, 32'h0000_2222}));
        chk_eq("t1_wr2", 64'(wr_log[2]), 64'({5'd7, 32'h0000_3333}));
        chk_eq("t1_wr_lat", 64'(wr_cyc[0] - first_hs), 64'd1);
        chk_eq("t1_wr_consec1", 64'(wr_cyc[1] - wr_cyc[0]), 64'd1);
        chk_eq("t1_wr_consec2", 64'(wr_cyc[2] - wr_cyc[0]), 64'd2);
        chk_eq("t1_nrd", 64'(rd_addr.size()), 64'd1);
        chk_eq("t1_rd_addr", 64'(rd_addr[0]), 64'd7);
        chk_eq("t1_rd_lat", 64'(rd_cyc[0] - done_c), 64'd1);
        chk_eq("t1_rsp_lat", 64'(rsp_seen_cyc - done_c), 64'd3);

        // round robin over channels 0, 1, 3 with completion held high
        reset_dut();
        bus.cmd_done = 1'b1;
        bus.host_data_out = 32'h0000_00A0;
        push_wr(0, 1'b1, 5'd7, 32'h0000_0100);
        push_wr(0, 1'b1, 5'd7, 32'h0000_0200);
        push_wr(1, 1'b1, 5'd7, 32'h0000_0101);
        push_wr(1, 1'b1, 5'd7, 32'h0000_0201);
        push_wr(3, 1'b1, 5'd7, 32'h0000_0103);
        push_wr(3, 1'b1, 5'd7, 32'h0000_0203);
        wait_rsp(0, 2'd0, 32'h0000_00A0, 0);
        wait_rsp(1, 2'd0, 32'h0000_00A0, 0);
        wait_rsp(3, 2'd0, 32'h0000_00A0, 0);
        wait_rsp(0, 2'd0, 32'h0000_00A0, 0);
        chk_eq("rr_w0", 64'(wr_log[0][31:0]), 64'h100);
        chk_eq("rr_w1", 64'(wr_log[1][31:0]), 64'h101);
        chk_eq("rr_w2", 64'(wr_log[2][31:0]), 64'h103);
        chk_eq("rr_w3", 64'(wr_log[3][31:0]), 64'h200);
        chk_eq("rr_one_ready", 64'(multi_rdy), 64'd0);

        // write hold for five cycles in mid-command
        reset_dut();
        bus.cmd_done = 1'b1;
        bus.host_data_out = 32'h0000_00B0;
        push_wr(2, 1'b0, 5'd1, 32'h0000_000A);
        push_wr(2, 1'b0, 5'd2, 32'h0000_000B);
        push_wr(2, 1'b0, 5'd3, 32'h0000_000C);
        push_wr(2, 1'b1, 5'd7, 32'h0000_000D);
        wait_hs(2);
        bus.write_hold_u = 1'b1;
        hold_c = cyc;
        repeat (5) tick();
        bus.write_hold_u = 1'b0;
        wait_rsp(2, 2'd0, 32'h0000_00B0, 0);
        nh = 0;
        foreach (wr_cyc[i]) begin
            if (wr_cyc[i] >= hold_c + 1 && wr_cyc[i] <= hold_c + 5) nh++;
        end
        chk_eq("hold_no_write", 64'(nh), 64'd0);
        chk_eq("hold_nwr", 64'(wr_log.size()), 64'd4);
        chk_eq("hold_w0", 64'(wr_log[0]), 64'({5'd1, 32'h0000_000A}));
        chk_eq("hold_w1", 64'(wr_log[1]), 64'({5'd2, 32'h0000_000B}));
        chk_eq("hold_w2", 64'(wr_log[2]), 64'({5'd3, 32'h0000_000C}));
        chk_eq("hold_w3", 64'(wr_log[3]), 64'({5'd7, 32'h0000_000D}));

        // timeout: no completion, read issued 16 cycles after WAIT_DONE entry
        reset_dut();
        bus.host_data_out = 32'hDEAD_0001;
        push_wr(1, 1'b1, 5'd7, 32'h0000_00EC);
        wait_hs(1);
        first_hs = last_hs_cyc;
        wait_rsp(1, 2'd2, 32'hDEAD_0001, 0);
        chk_eq("tmo_nrd", 64'(rd_cyc.size()), 64'd1);
        chk_eq("tmo_rd_cycle", 64'(rd_cyc[0] - first_hs), 64'd17);

        // error and completion together give device error
        bus.host_data_out = 32'h0000_0051;
        push_wr(3, 1'b1, 5'd7, 32'h0000_0033);
        wait_hs(3);
        repeat (3) tick();
        bus.r_err = 1'b1;
        bus.cmd_done = 1'b1;
        tick();
        bus.r_err = 1'b0;
        bus.cmd_done = 1'b0;
        wait_rsp(3, 2'd1, 32'h0000_0051, 0);

        // illegal_state alone gives device error
        bus.host_data_out = 32'h0000_0052;
        push_wr(0, 1'b1, 5'd7, 32'h0000_0044);
        wait_hs(0);
        repeat (2) tick();
        bus.illegal_state = 1'b1;
        tick();
        bus.illegal_state = 1'b0;
        wait_rsp(0, 2'd1, 32'h0000_0052, 0);

        // r_err before WAIT_DONE is ignored; ipf completes OK
        bus.host_data_out = 32'h0000_0077;
        bus.r_err = 1'b1;
        push_wr(1, 1'b1, 5'd7, 32'h0000_0055);
        wait_hs(1);
        bus.r_err = 1'b0;
        tick();
        bus.ipf = 1'b1;
        tick();
        bus.ipf = 1'b0;
        wait_rsp(1, 2'd0, 32'h0000_0077, 0);

        // link loss during ISSUE after one of three writes
        clear_logs();
        bus.host_data_out = 32'h0000_0099;
        push_wr(2, 1'b0, 5'd1, 32'h0000_0001);
        push_wr(2, 1'b0, 5'd2, 32'h0000_0002);
        push_wr(2, 1'b1, 5'd7, 32'h0000_0003);
        wait_hs(2);
        bus.linkup = 1'b0;
        drop_c = cyc;
        tick();
        wait_rsp(2, 2'd3, 32'h0000_0000, 0);
        chk_eq("link_rsp_lat", 64'(rsp_seen_cyc - drop_c), 64'd1);
        chk_eq("link_nwr", 64'(wr_log.size()), 64'd1);
        chk_eq("link_no_read", 64'(rd_addr.size()), 64'd0);
        ch_q[2].delete();
        drive_ch();
        bus.linkup = 1'b1;
        tick();

        // reset while a response is pending
        bus.cmd_done = 1'b1;
        push_wr(3, 1'b1, 5'd7, 32'h0000_0066);
        n = 0;
        while (bus.rsp_valid == '0 && n < 50) begin
            tick();
            n++;
        end
        chk_eq("rr_pre_reset_rsp", 64'(bus.rsp_valid), 64'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cmd_done = 1'b0;
        chk_eq("rst_resp_valid", 64'(bus.rsp_valid), 64'd0);
        chk_eq("rst_resp_code", 64'(bus.rsp_code), 64'd0);
        nh = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid != '0) nh++;
        end
        chk_eq("rst_no_late_rsp", 64'(nh), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
